id_stage_top: RTL
=================

# id_stage_top

Instruction-decode stage of the 5-stage RV32I pipeline. It sits directly downstream of the fetch stage and consumes the IF/ID register outputs (instruction, PC+4). It contains the 32×32 register file, the main decoder, the immediate generator, load-use hazard detection and the ID/EX pipeline register. It drives the fetch stage's `pc_write` and `if_id_write` stall controls and inserts bubbles on stalls and taken-branch flushes.

## Interface
- None. All widths are fixed by RV32I: 32-bit data, 5-bit register indices.

- `clk` in 1 — rising-edge clock.
- `reset` in 1 — asynchronous, active-low; clears all state.
- `if_id_instr` in 32 — instruction being decoded.
- `if_id_pc_plus4` in 32 — PC+4 of that instruction.
- `branch_taken` in 1 — from EX; redirect this cycle, squash younger instructions.
- `wb_reg_write` in 1 — writeback enable.
- `wb_rd` in 5 — writeback destination.
- `wb_data` in 32 — writeback value.
- `pc_write` out 1 — to fetch; 0 = hold PC.
- `if_id_write` out 1 — to fetch; 0 = hold IF/ID.
- `id_ex_pc_plus4` out 32; `id_ex_rs1_data` out 32; `id_ex_rs2_data` out 32; `id_ex_imm` out 32.
- `id_ex_rs1`, `id_ex_rs2`, `id_ex_rd` out 5 each; `id_ex_funct3` out 3; `id_ex_funct7b5` out 1.
- `id_ex_alu_op` out 2 — 00 add, 01 branch compare, 10 R-type, 11 I-type ALU.
- `id_ex_alu_src`, `id_ex_mem_read`, `id_ex_mem_write`, `id_ex_mem_to_reg`, `id_ex_reg_write`, `id_ex_branch`, `id_ex_jump`, `id_ex_lui` out 1 each.

## Operation
- **Decode by opcode `[6:0]`:**
  - R 0110011: reg_write, alu_op=10.
  - I-ALU 0010011: reg_write, alu_src, alu_op=11.
  - Load 0000011: reg_write, alu_src, mem_read, mem_to_reg, alu_op=00.
  - Store 0100011: alu_src, mem_write, alu_op=00.
  - Branch 1100011: branch, alu_op=01.
  - JAL 1101111: jump, reg_write, alu_op=00.
  - LUI 0110111: lui, reg_write, alu_src, alu_op=00.
  - Any other opcode: all controls 0 (NOP).
- **Immediates** (sign-extended from bit 31):
  - I: `[31:20]`.
  - S: `{[31:25],[11:7]}`.
  - B: `{[31],[7],[30:25],[11:8],0}`.
  - J: `{[31],[19:12],[20],[30:21],0}`.
  - U: `{[31:12],12'b0}`.
  - R/unknown: 0.
- **Register file:**
  - x0 always reads 0 and is never written.
  - Write on rising edge when `wb_reg_write && wb_rd!=0`.
  - Reads are combinational with write-through: if the same cycle writes `rs1`/`rs2` (nonzero), the read returns `wb_data`.
- **Load-use hazard:** `stall = id_ex_mem_read && id_ex_rd!=0 && (id_ex_rd==instr[19:15] || id_ex_rd==instr[24:20])`. Comparison is done for every format (conservative).
  - On stall: `pc_write=0`, `if_id_write=0`; ID/EX loads a bubble.
- **Bubble:** every `id_ex_*` output is 0.
- **Flush:**
  - `branch_taken=1` loads a bubble into ID/EX and sets internal `squash_pending`.
  - While `squash_pending=1`, the next decoded instruction also becomes a bubble; the flag clears on that edge.
  - Two wrong-path instructions are removed in total.
- **Priority:** flush > stall. With `branch_taken=1`, `pc_write=if_id_write=1` regardless of stall. A hazard with a squashed instruction does not stall.
- **Otherwise:** ID/EX captures the decoded fields, register data, immediate and `if_id_pc_plus4`.

## Timing
- Reset (`reset=0`, asynchronous):
  - All `id_ex_*` = 0.
  - All 32 registers = 0.
  - `squash_pending=0`.
  - `pc_write=if_id_write=1` (combinational from cleared state).
- Decode to ID/EX: 1 cycle. Fields are visible to EX the cycle after the instruction sits in IF/ID.
- `pc_write` and `if_id_write` are combinational from the current `if_id_instr` and ID/EX state, valid within the same cycle.
- A load-use stall lasts exactly 1 cycle. After the bubble, `id_ex_mem_read=0`, so the stall releases.
- Simultaneous WB write and read of the same register returns the new value with zero-cycle bypass.
- `branch_taken` during `squash_pending=1`: a bubble is inserted and the flag stays set, so one more instruction is squashed.
- Reset asserted mid-operation: all state clears immediately, with no dependence on the clock.

## Test plan
- Reset, then `addi x1,x0,5` (0x00500093) → next cycle `id_ex_reg_write=1`, `alu_src=1`, `alu_op=11`, `id_ex_rd=1`, `imm=5`, `rs1_data=0`.
- WB writes x3=0xDEADBEEF while decoding `add x4,x3,x3` in the same cycle → `id_ex_rs1_data=id_ex_rs2_data=0xDEADBEEF`. A WB write to x0 (attempted value 0x1234), then reading x0 → 0.
- `lw x5,0(x1)` followed by `add x6,x5,x2` → one cycle with `pc_write=if_id_write=0` and an all-zero ID/EX bubble; the `add` enters ID/EX on the next cycle.
- `branch_taken` pulsed for 1 cycle → the two following ID/EX loads are bubbles; the third instruction passes normally.
- Each immediate format with bit 31 set:
  - `sw` with imm −4 → imm=0xFFFFFFFC.
  - `beq` with offset −8 → imm=0xFFFFFFF8.
  - `jal` with offset −2048 → imm=0xFFFFF800.
  - `lui` 0xABCDE → imm=0xABCDE000.
- Unknown opcode 0x0000007F → all controls 0. Asserting `reset` low mid-stream → all `id_ex_*` read 0 immediately (asynchronously).

Source files
------------

// File: rtl/id_stage_top_if.sv
// Signal bundle between the RV32I decode stage and its neighbours (IF/ID, WB, EX, fetch).
interface id_stage_top_if;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc_plus4;
    logic        branch_taken;
    logic        wb_reg_write;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;

    logic        pc_write;
    logic        if_id_write;

    logic [31:0] id_ex_pc_plus4;
    logic [31:0] id_ex_rs1_data;
    logic [31:0] id_ex_rs2_data;
    logic [31:0] id_ex_imm;
    logic [4:0]  id_ex_rs1;
    logic [4:0]  id_ex_rs2;
    logic [4:0]  id_ex_rd;
    logic [2:0]  id_ex_funct3;
    logic        id_ex_funct7b5;
    logic [1:0]  id_ex_alu_op;
    logic        id_ex_alu_src;
    logic        id_ex_mem_read;
    logic        id_ex_mem_write;
    logic        id_ex_mem_to_reg;
    logic        id_ex_reg_write;
    logic        id_ex_branch;
    logic        id_ex_jump;
    logic        id_ex_lui;

    // Environment side: supplies instruction/writeback/redirect, observes ID/EX.
    modport master (
        output if_id_instr, if_id_pc_plus4, branch_taken, wb_reg_write, wb_rd, wb_data,
        input  pc_write, if_id_write,
        input  id_ex_pc_plus4, id_ex_rs1_data, id_ex_rs2_data, id_ex_imm,
        input  id_ex_rs1, id_ex_rs2, id_ex_rd, id_ex_funct3, id_ex_funct7b5, id_ex_alu_op,
        input  id_ex_alu_src, id_ex_mem_read, id_ex_mem_write, id_ex_mem_to_reg,
        input  id_ex_reg_write, id_ex_branch, id_ex_jump, id_ex_lui
    );

    // Decode stage side.
    modport slave (
        input  if_id_instr, if_id_pc_plus4, branch_taken, wb_reg_write, wb_rd, wb_data,
        output pc_write, if_id_write,
        output id_ex_pc_plus4, id_ex_rs1_data, id_ex_rs2_data, id_ex_imm,
        output id_ex_rs1, id_ex_rs2, id_ex_rd, id_ex_funct3, id_ex_funct7b5, id_ex_alu_op,
        output id_ex_alu_src, id_ex_mem_read, id_ex_mem_write, id_ex_mem_to_reg,
        output id_ex_reg_write, id_ex_branch, id_ex_jump, id_ex_lui
    );
endinterface

// File: rtl/id_stage_top.sv
// RV32I instruction-decode stage: register file, decoder, immediate generator,
// load-use stall detection, branch flush and the ID/EX pipeline register.
module id_stage_top (
    input  logic          clk,
    input  logic          reset,
    id_stage_top_if.slave bus
);
    localparam int unsigned XLEN = 32;
    localparam int unsigned RIDX = 5;
    localparam int unsigned NREG = 32;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I_ALU  = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    typedef struct packed {
        logic [XLEN-1:0] pc_plus4;
        logic [XLEN-1:0] rs1_data;
        logic [XLEN-1:0] rs2_data;
        logic [XLEN-1:0] imm;
        logic [RIDX-1:0] rs1;
        logic [RIDX-1:0] rs2;
        logic [RIDX-1:0] rd;
        logic [2:0]      funct3;
        logic            funct7b5;
        logic [1:0]      alu_op;
        logic            alu_src;
        logic            mem_read;
        logic            mem_write;
        logic            mem_to_reg;
        logic            reg_write;
        logic            branch;
        logic            jump;
        logic            lui;
    } id_ex_t;

    logic [XLEN-1:0] regs [NREG];
    logic [XLEN-1:0] rs1_data_c;
    logic [XLEN-1:0] rs2_data_c;
    logic [XLEN-1:0] imm_c;
    logic [RIDX-1:0] rs1_c;
    logic [RIDX-1:0] rs2_c;
    logic [6:0]      opcode_c;
    logic            hazard_c;
    logic            squash_c;
    logic            stall_c;
    logic            squash_pending;
    id_ex_t          id_ex_q;
    id_ex_t          id_ex_d;
    id_ex_t          dec_c;

    assign opcode_c = bus.if_id_instr[6:0];
    assign rs1_c    = bus.if_id_instr[19:15];
    assign rs2_c    = bus.if_id_instr[24:20];

    // Register file storage; x0 is never written so it stays zero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < int'(NREG); i++) begin
                regs[i] <= '0;
            end
        end else if (bus.wb_reg_write && (bus.wb_rd != '0)) begin
            regs[bus.wb_rd] <= bus.wb_data;
        end
    end

    // Combinational reads with same-cycle writeback bypass.
    always_comb begin
        rs1_data_c = regs[rs1_c];
        rs2_data_c = regs[rs2_c];
        if (bus.wb_reg_write && (bus.wb_rd == rs1_c)) rs1_data_c = bus.wb_data;
        if (bus.wb_reg_write && (bus.wb_rd == rs2_c)) rs2_data_c = bus.wb_data;
        if (rs1_c == '0) rs1_data_c = '0;
        if (rs2_c == '0) rs2_data_c = '0;
    end

    // Immediate generation, sign-extended from bit 31.
    always_comb begin
        imm_c = '0;
        case (opcode_c)
            OP_I_ALU, OP_LOAD: imm_c = {{20{bus.if_id_instr[31]}}, bus.if_id_instr[31:20]};
            OP_STORE:  imm_c = {{20{bus.if_id_instr[31]}}, bus.if_id_instr[31:25],
                                bus.if_id_instr[11:7]};
            OP_BRANCH: imm_c = {{20{bus.if_id_instr[31]}}, bus.if_id_instr[7],
                                bus.if_id_instr[30:25], bus.if_id_instr[11:8], 1'b0};
            OP_JAL:    imm_c = {{12{bus.if_id_instr[31]}}, bus.if_id_instr[19:12],
                                bus.if_id_instr[20], bus.if_id_instr[30:21], 1'b0};
            OP_LUI:    imm_c = {bus.if_id_instr[31:12], 12'b0};
            default:   imm_c = '0;
        endcase
    end

    // Main decoder: assemble the full ID/EX payload for the current instruction.
    always_comb begin
        dec_c          = '0;
        dec_c.pc_plus4 = bus.if_id_pc_plus4;
        dec_c.rs1_data = rs1_data_c;
        dec_c.rs2_data = rs2_data_c;
        dec_c.imm      = imm_c;
        dec_c.rs1      = rs1_c;
        dec_c.rs2      = rs2_c;
        dec_c.rd       = bus.if_id_instr[11:7];
        dec_c.funct3   = bus.if_id_instr[14:12];
        dec_c.funct7b5 = bus.if_id_instr[30];
        case (opcode_c)
            OP_R: begin
                dec_c.reg_write = 1'b1;
                dec_c.alu_op    = 2'b10;
            end
            OP_I_ALU: begin
                dec_c.reg_write = 1'b1;
                dec_c.alu_src   = 1'b1;
                dec_c.alu_op    = 2'b11;
            end
            OP_LOAD: begin
                dec_c.reg_write  = 1'b1;
                dec_c.alu_src    = 1'b1;
                dec_c.mem_read   = 1'b1;
                dec_c.mem_to_reg = 1'b1;
            end
            OP_STORE: begin
                dec_c.alu_src   = 1'b1;
                dec_c.mem_write = 1'b1;
            end
            OP_BRANCH: begin
                dec_c.branch = 1'b1;
                dec_c.alu_op = 2'b01;
            end
            OP_JAL: begin
                dec_c.jump      = 1'b1;
                dec_c.reg_write = 1'b1;
            end
            OP_LUI: begin
                dec_c.lui       = 1'b1;
                dec_c.reg_write = 1'b1;
                dec_c.alu_src   = 1'b1;
            end
            default: ;
        endcase
    end

    // Hazard/flush control; a squashed instruction never stalls the front end.
    always_comb begin
        hazard_c = id_ex_q.mem_read && (id_ex_q.rd != '0) &&
                   ((id_ex_q.rd == rs1_c) || (id_ex_q.rd == rs2_c));
        squash_c = bus.branch_taken || squash_pending;
        stall_c  = hazard_c && !squash_c;
        id_ex_d  = (squash_c || stall_c) ? id_ex_t'('0) : dec_c;
    end

    assign bus.pc_write    = !stall_c;
    assign bus.if_id_write = !stall_c;

    // ID/EX register and second-slot squash flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            id_ex_q        <= '0;
            squash_pending <= 1'b0;
        end else begin
            id_ex_q        <= id_ex_d;
            squash_pending <= bus.branch_taken;
        end
    end

    assign bus.id_ex_pc_plus4   = id_ex_q.pc_plus4;
    assign bus.id_ex_rs1_data   = id_ex_q.rs1_data;
    assign bus.id_ex_rs2_data   = id_ex_q.rs2_data;
    assign bus.id_ex_imm        = id_ex_q.imm;
    assign bus.id_ex_rs1        = id_ex_q.rs1;
    assign bus.id_ex_rs2        = id_ex_q.rs2;
    assign bus.id_ex_rd         = id_ex_q.rd;
    assign bus.id_ex_funct3     = id_ex_q.funct3;
    assign bus.id_ex_funct7b5   = id_ex_q.funct7b5;
    assign bus.id_ex_alu_op     = id_ex_q.alu_op;
    assign bus.id_ex_alu_src    = id_ex_q.alu_src;
    assign bus.id_ex_mem_read   = id_ex_q.mem_read;
    assign bus.id_ex_mem_write  = id_ex_q.mem_write;
    assign bus.id_ex_mem_to_reg = id_ex_q.mem_to_reg;
    assign bus.id_ex_reg_write  = id_ex_q.reg_write;
    assign bus.id_ex_branch     = id_ex_q.branch;
    assign bus.id_ex_jump       = id_ex_q.jump;
    assign bus.id_ex_lui        = id_ex_q.lui;
endmodule
